ethernet_cmd_arbiter: RTL
=========================

# ethernet_cmd_arbiter

Shares the Ethernet controller's single register-access port between two requesters: requester 0 is the host AXI-lite client adaptor and requester 1 is the on-chip core's MMIO path. The block grants round-robin and keeps exactly one access outstanding in the controller. It generates write acknowledgements locally, waits for the controller's synchronous read data, and steers each response back to the requester that issued the access. A timeout guarantees a response even if read data never returns. It sits between the command/response adaptors and the Ethernet controller wrapper, replacing the single-requester outstanding-request logic.

## Interface
- data_width_p, 32: register data width
- addr_width_p, 32: register address width
- size_width_p, 2: op-size field width
- timeout_p, 16: cycles to wait for read data before an error response (at least 2)
- err_data_p, 32'hDEAD_BEEF: read data returned on timeout
- clk_i  in  1  sole clock
- reset_i  in  1  asynchronous, active-high reset
- req_v_i  in  2  command valid, one bit per requester
- req_ready_and_o  out  2  command accepted when this and req_v_i are both high
- req_addr_i  in  2*addr_width_p  address; requester n at slice n
- req_wr_en_i  in  2  1 = write, 0 = read
- req_size_i  in  2*size_width_p  op size
- req_wdata_i  in  2*data_width_p  write data
- resp_v_o  out  2  response valid, one-hot or zero
- resp_ready_and_i  in  2  response consumed when this and resp_v_o are both high
- resp_rdata_o  out  data_width_p  response data, shared by both requesters
- resp_err_o  out  1  response is a timeout error
- addr_o  out  addr_width_p  controller address
- write_en_o  out  1  controller write strobe, one cycle
- read_en_o  out  1  controller read strobe, one cycle
- op_size_o  out  size_width_p  controller op size
- write_data_o  out  data_width_p  controller write data
- read_data_i  in  data_width_p  controller read data
- read_data_v_i  in  1  controller read data valid

## Operation
- States:
  - IDLE: ready for a new command.
  - ISSUE: drive one strobe to the controller.
  - WAIT: wait for read data.
  - RESP: present the response to the owner.
- IDLE:
  - Grant: if only one req_v_i bit is high, grant that requester. If both are high, grant the requester other than last_grant_r.
  - req_ready_and_o is high only for the granted requester, and only in IDLE.
  - On handshake, latch addr, wr_en, size, wdata and owner_r. Go to ISSUE.
- ISSUE:
  - For a latched write, pulse write_en_o, load resp_data_r with 0 and resp_err_r with 0, then go to RESP.
  - For a latched read, pulse read_en_o, clear the timeout counter, then go to WAIT.
  - addr_o, op_size_o and write_data_o come from the latched registers. They hold their values in every state.
- WAIT:
  - The counter increments every cycle.
  - If read_data_v_i is high, capture read_data_i with err 0 and go to RESP.
  - Otherwise, if the counter reaches timeout_p-1, capture err_data_p with err 1 and go to RESP.
  - If both happen in the same cycle, the data wins.
- RESP:
  - resp_v_o[owner_r] is high, with resp_rdata_o = resp_data_r and resp_err_o = resp_err_r.
  - On resp_ready_and_i[owner_r]: last_grant_r <= owner_r, then go to IDLE.
  - The other requester's resp_ready_and_i is ignored.
- read_data_v_i outside WAIT (late data after a timeout, or spurious) is ignored and has no effect on state or data.
- A requester can drop req_v_i before it is granted; the arbiter then re-evaluates the grant in the next cycle.

## Timing
- Reset (asynchronous):
  - State returns to IDLE and last_grant_r is set to 1, so requester 0 wins the first tie.
  - All outputs are 0: strobes, resp_v_o, resp_err_o, resp_rdata_o, addr_o, op_size_o, write_data_o. req_ready_and_o reads 0 while reset is asserted.
  - Reset asserted mid-access drops the access with no response. The controller may have seen a strobe.
- Write, accepted at cycle t:
  - write_en_o at t+1.
  - resp_v_o at t+2 at the earliest.
- Read, accepted at t:
  - read_en_o at t+1.
  - The controller returns read_data_v_i at t+2, so resp_v_o rises at t+3.
- Timeout: resp_v_o rises timeout_p+1 cycles after read_en_o.
- The response holds stable until it is consumed. At most one access is in flight.
- Back-to-back throughput: the next command is accepted in the cycle after the response handshake, giving a minimum of 3 cycles per write and 4 per read.
- Each strobe is exactly one cycle wide. write_en_o and read_en_o are never high together.

## Test plan
- Single write: requester 0 writes addr 0x1010 with data 0xA5A5_0001 -> write_en_o=1 for one cycle at t+1 with addr_o=0x1010 and write_data_o=0xA5A5_0001; resp_v_o=2'b01 with rdata 0 and err 0 at t+2.
- Single read: requester 1 reads 0x2000; the controller model returns 0x1234_5678 one cycle after read_en_o -> resp_v_o=2'b10 with rdata 0x1234_5678 and err 0 at t+3.
- Contention: both requesters hold valid for 4 accesses -> grant order 0,1,0,1, with each response going only to its owner.
- Response backpressure: hold resp_ready_and_i low for 5 cycles -> resp_v_o and resp_rdata_o stay stable, no new command is accepted, and strobes stay low.
- Timeout: with timeout_p=16, the controller never asserts read_data_v_i -> resp_v_o 17 cycles after read_en_o, rdata 0xDEAD_BEEF, err 1. Late read_data_v_i after that point is ignored.
- Reset mid-WAIT: assert reset_i during WAIT -> all outputs are 0 immediately. After release, requester 0 wins a tie.

Source files
------------

// File: rtl/ethernet_cmd_arbiter.sv
// Two-requester round-robin front end for the Ethernet controller register port.
// One access in flight; write acks generated locally, reads wait for data or time out.
module ethernet_cmd_arbiter #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned size_width_p = 2,
  parameter int unsigned timeout_p    = 16,
  parameter logic [data_width_p-1:0] err_data_p = 32'hDEAD_BEEF
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [1:0]                    req_v_i,
  output logic [1:0]                    req_ready_and_o,
  input  logic [1:0][addr_width_p-1:0]  req_addr_i,
  input  logic [1:0]                    req_wr_en_i,
  input  logic [1:0][size_width_p-1:0]  req_size_i,
  input  logic [1:0][data_width_p-1:0]  req_wdata_i,
  output logic [1:0]                    resp_v_o,
  input  logic [1:0]                    resp_ready_and_i,
  output logic [data_width_p-1:0]       resp_rdata_o,
  output logic                          resp_err_o,
  output logic [addr_width_p-1:0]       addr_o,
  output logic                          write_en_o,
  output logic                          read_en_o,
  output logic [size_width_p-1:0]       op_size_o,
  output logic [data_width_p-1:0]       write_data_o,
  input  logic [data_width_p-1:0]       read_data_i,
  input  logic                          read_data_v_i
);

  localparam int unsigned cnt_w_lp = $clog2(timeout_p) + 1;
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(timeout_p - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [addr_width_p-1:0] addr;
    logic                    wr;
    logic [size_width_p-1:0] size;
    logic [data_width_p-1:0] wdata;
  } cmd_t;

  state_e                  state_r;
  cmd_t                    cmd_r;
  logic                    owner_r;
  logic                    last_grant_r;
  logic [cnt_w_lp-1:0]     cnt_r;
  logic [data_width_p-1:0] resp_data_r;
  logic                    resp_err_r;
  logic [1:0]              resp_v_r;
  logic                    grant;
  logic                    hs;

  // Tie goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    case (req_v_i)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_r;
      default: grant = 1'b0;
    endcase
  end

  assign req_ready_and_o = (state_r == IDLE && !reset_i && req_v_i != 2'b00)
                         ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign hs = |(req_ready_and_o & req_v_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= IDLE;
      cmd_r        <= '0;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      cnt_r        <= '0;
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
      resp_v_r     <= 2'b00;
      write_en_o   <= 1'b0;
      read_en_o    <= 1'b0;
    end else begin
      write_en_o <= 1'b0;
      read_en_o  <= 1'b0;
      case (state_r)
        IDLE: if (hs) begin
          cmd_r.addr  <= req_addr_i[grant];
          cmd_r.wr    <= req_wr_en_i[grant];
          cmd_r.size  <= req_size_i[grant];
          cmd_r.wdata <= req_wdata_i[grant];
          owner_r     <= grant;
          // Strobe is registered so it lands in the ISSUE cycle.
          write_en_o  <= req_wr_en_i[grant];
          read_en_o   <= ~req_wr_en_i[grant];
          state_r     <= ISSUE;
        end
        ISSUE: begin
          if (cmd_r.wr) begin
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
            resp_v_r    <= owner_r ? 2'b10 : 2'b01;
            state_r     <= RESP;
          end else begin
            cnt_r   <= '0;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r + 1'b1;
          if (read_data_v_i) begin
            resp_data_r <= read_data_i;
            resp_err_r  <= 1'b0;
            resp_v_r    <= owner_r ? 2'b10 : 2'b01;
            state_r     <= RESP;
          end else if (cnt_r == cnt_last_lp) begin
            resp_data_r <= err_data_p;
            resp_err_r  <= 1'b1;
            resp_v_r    <= owner_r ? 2'b10 : 2'b01;
            state_r     <= RESP;
          end
        end
        RESP: if (resp_ready_and_i[owner_r]) begin
          resp_v_r     <= 2'b00;
          last_grant_r <= owner_r;
          state_r      <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign resp_v_o     = resp_v_r;
  assign resp_rdata_o = resp_data_r;
  assign resp_err_o   = resp_err_r;
  assign addr_o       = cmd_r.addr;
  assign op_size_o    = cmd_r.size;
  assign write_data_o = cmd_r.wdata;

endmodule
